// File: rtl/rr_reg_arbiter.sv
// Round-robin write arbiter in front of a shared WIDTH-bit register: one grant per two cycles,
// gnt is registered one cycle after req is sampled, q loads on the following edge; losers hold req and wait.
module rr_reg_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] wdata,
  output logic [N-1:0]       gnt,
  output logic [WIDTH-1:0]   q,
  output logic               busy,
  output logic [IDW-1:0]     last_id
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0]   stage_q, stage_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [IDW-1:0]     last_id_q, last_id_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     win_q, win_d;

  logic               win_found;
  logic [IDW-1:0]     win_idx;
  int unsigned        idx;

  // Search upward from ptr with wrap; works for N that is not a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    stage_d   = stage_q;
    data_d    = data_q;
    last_id_d = last_id_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          gnt_d   = N'(1) << win_idx;
          stage_d = wdata[int'(win_idx)*WIDTH +: WIDTH];
          win_d   = win_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        data_d    = stage_q;
        last_id_d = win_q;
        ptr_d     = (win_q == IDW'(N-1)) ? '0 : win_q + IDW'(1);
        gnt_d     = '0;
        state_d   = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      stage_q   <= '0;
      data_q    <= '0;
      last_id_q <= '0;
      ptr_q     <= '0;
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      stage_q   <= stage_d;
      data_q    <= data_d;
      last_id_q <= last_id_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = data_q;
  assign busy    = (state_q == GRANT);
  assign last_id = last_id_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter: vector table for rotation/wrap/single requester, hand sequences for the rest.
module tb_rr_reg_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  q;
  logic        busy;
  logic [1:0]  last_id;

  int n_checks = 0;
  int n_fail   = 0;

  rr_reg_arbiter #(.N(4), .WIDTH(4), .IDW(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .busy    (busy),
    .last_id (last_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  q;
    logic        busy;
    logic [1:0]  last_id;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [3:0] e_q,
                         input logic e_busy, input logic [1:0] e_last);
    chk({tag, " gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, " q"}, 32'(q), 32'(e_q));
    chk({tag, " busy"}, 32'(busy), 32'(e_busy));
    chk({tag, " last_id"}, 32'(last_id), 32'(e_last));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Rotation 0..3, wrap to 0 with req=1001, then fairness to 3, then a lone requester 2.
    vecs[0]  = '{4'hF, 16'h4321, 4'b0001, 4'h0, 1'b1, 2'd0};
    vecs[1]  = '{4'hF, 16'h4321, 4'b0000, 4'h1, 1'b0, 2'd0};
    vecs[2]  = '{4'hF, 16'h4321, 4'b0010, 4'h1, 1'b1, 2'd0};
    vecs[3]  = '{4'hF, 16'h4321, 4'b0000, 4'h2, 1'b0, 2'd1};
    vecs[4]  = '{4'hF, 16'h4321, 4'b0100, 4'h2, 1'b1, 2'd1};
    vecs[5]  = '{4'hF, 16'h4321, 4'b0000, 4'h3, 1'b0, 2'd2};
    vecs[6]  = '{4'hF, 16'h4321, 4'b1000, 4'h3, 1'b1, 2'd2};
    vecs[7]  = '{4'hF, 16'h4321, 4'b0000, 4'h4, 1'b0, 2'd3};
    vecs[8]  = '{4'h9, 16'h4321, 4'b0001, 4'h4, 1'b1, 2'd3};
    vecs[9]  = '{4'h9, 16'h4321, 4'b0000, 4'h1, 1'b0, 2'd0};
    vecs[10] = '{4'h9, 16'h4321, 4'b1000, 4'h1, 1'b1, 2'd0};
    vecs[11] = '{4'h9, 16'h4321, 4'b0000, 4'h4, 1'b0, 2'd3};
    vecs[12] = '{4'h4, 16'h3C21, 4'b0100, 4'h4, 1'b1, 2'd3};
    vecs[13] = '{4'h4, 16'h3C21, 4'b0000, 4'hC, 1'b0, 2'd2};
    vecs[14] = '{4'h0, 16'h3C21, 4'b0000, 4'hC, 1'b0, 2'd2};
    vecs[15] = '{4'h0, 16'h0000, 4'b0000, 4'hC, 1'b0, 2'd2};

    // Reset asserted from time zero with all requesters active; checked before any edge.
    reset = 1'b1;
    req   = 4'hF;
    wdata = 16'hA5C3;
    #2;
    chk_all("reset", 4'b0000, 4'h0, 1'b0, 2'd0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req   = vecs[i].req;
      wdata = vecs[i].wdata;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].busy, vecs[i].last_id);
    end

    // Requester 1 withdraws before any edge sees it: nothing is granted or written.
    req   = 4'b0010;
    wdata = 16'h00E0;
    #3;
    req   = 4'b0000;
    step();
    chk_all("withdraw", 4'b0000, 4'hC, 1'b0, 2'd2);
    step();
    chk_all("withdraw2", 4'b0000, 4'hC, 1'b0, 2'd2);

    // Data changes while gnt[2] is high: the value captured at the grant edge is written.
    req   = 4'b0100;
    wdata = 16'h0500;
    step();
    chk_all("dchg_gnt", 4'b0100, 4'hC, 1'b1, 2'd2);
    wdata = 16'h0F00;
    req   = 4'b0000;
    step();
    chk_all("dchg_wr", 4'b0000, 4'h5, 1'b0, 2'd2);

    // Reset 2 ns into a grant with 6 staged; pointer is 3 here, so req=1001 after release shows it restarted at 0.
    req   = 4'b0100;
    wdata = 16'h0600;
    @(posedge clk);
    #1;
    chk("mid_pre gnt", 32'(gnt), 32'(4'b0100));
    #1;
    reset = 1'b1;
    #1;
    chk_all("mid_rst", 4'b0000, 4'h0, 1'b0, 2'd0);
    req = 4'b0000;
    step();
    chk_all("mid_hold", 4'b0000, 4'h0, 1'b0, 2'd0);
    reset = 1'b0;
    step();
    chk_all("post_idle", 4'b0000, 4'h0, 1'b0, 2'd0);
    req   = 4'b1001;
    wdata = 16'h9007;
    step();
    chk_all("post_gnt", 4'b0001, 4'h0, 1'b1, 2'd0);
    req = 4'b0000;
    step();
    chk_all("post_wr", 4'b0000, 4'h7, 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
